// File: rtl/full_adder_pkg.sv
// Shared constants and result bundle for the registered ripple-carry adder.
package full_adder_pkg;

   localparam int FA_MAX_WIDTH     = 64;
   localparam int FA_DEFAULT_WIDTH = 1;

   // Widest result shape; narrower consumers take the low s bits.
   typedef struct packed {
      logic                    c1;
      logic [FA_MAX_WIDTH-1:0] s;
   } fa_result_t;

   function automatic fa_result_t fa_pack(input logic c1, input logic [FA_MAX_WIDTH-1:0] s);
      fa_result_t r;
      r.c1 = c1;
      r.s  = s;
      return r;
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder; the leaf of the ripple chain.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {C1,S} = A + B + C0, one cycle of latency.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
   output logic [WIDTH-1:0] S,
   output logic             C1,
   output logic             valid
);

   localparam int STAGES = 1;

   typedef struct packed {
      logic             c1;
      logic [WIDTH-1:0] s;
   } res_t;

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;
   logic [STAGES:0]  vld_pipe;
   res_t             res_d;
   res_t             res_q;

   assign carry[0] = C0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_cell (
         .a  (A[i]),
         .b  (B[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   assign res_d.c1    = carry[WIDTH];
   assign res_d.s     = sum;
   assign vld_pipe[0] = en;

   // Result only loads on en; valid tracks en so it drops on hold cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q            <= '0;
         vld_pipe[STAGES] <= 1'b0;
      end else begin
         vld_pipe[STAGES] <= vld_pipe[STAGES-1];
         if (en) res_q <= res_d;
      end
   end

   assign S     = res_q.s;
   assign C1    = res_q.c1;
   assign valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_full_adder.sv
// Randomized + directed check of full_adder at WIDTH=1 and WIDTH=8 against an arithmetic model.
module tb_full_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en;
   logic       a1, b1, c01, s1, co1, v1;
   logic [7:0] a8, b8, s8;
   logic       c08, co8, v8;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] m_s8;
   logic       m_c8, m_s1, m_c1, m_v;

   full_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .A(a1), .B(b1), .C0(c01),
      .S(s1), .C1(co1), .valid(v1)
   );

   full_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .en(en), .A(a8), .B(b8), .C0(c08),
      .S(s8), .C1(co8), .valid(v8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model computes the next registered state from the inputs, then the edge is taken.
   task automatic tick();
      logic [8:0] sum8;
      logic [1:0] sum1;
      sum8 = 9'(a8) + 9'(b8) + 9'(c08);
      sum1 = 2'(a1) + 2'(b1) + 2'(c01);
      if (rst) begin
         m_s8 = '0; m_c8 = 1'b0; m_s1 = 1'b0; m_c1 = 1'b0; m_v = 1'b0;
      end else if (en) begin
         m_s8 = sum8[7:0]; m_c8 = sum8[8];
         m_s1 = sum1[0];   m_c1 = sum1[1];
         m_v  = 1'b1;
      end else begin
         m_v = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("s1",  64'(s1),  64'(m_s1));
      chk("c1",  64'(co1), 64'(m_c1));
      chk("v1",  64'(v1),  64'(m_v));
      chk("s8",  64'(s8),  64'(m_s8));
      chk("c8",  64'(co8), 64'(m_c8));
      chk("v8",  64'(v8),  64'(m_v));
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
      a8 = a; b8 = b; c08 = c;
   endtask

   logic [1:0] tab [8];

   initial begin
      // {S,C1} for {A,B,C0} = 0..7
      tab = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
      rst = 1'b1; en = 1'b1;
      a1 = 1'b1; b1 = 1'b1; c01 = 1'b1;
      drive8(8'h01, 8'h01, 1'b1);
      m_s8 = '0; m_c8 = 1'b0; m_s1 = 1'b0; m_c1 = 1'b0; m_v = 1'b0;
      @(negedge clk);

      // reset overrides en
      repeat (2) begin
         tick();
         chk("rst_s1", 64'(s1), 64'd0);
         chk("rst_v1", 64'(v1), 64'd0);
      end
      rst = 1'b0;
      tick();
      chk("post_rst_s1", 64'(s1),  64'd1);
      chk("post_rst_c1", 64'(co1), 64'd1);
      chk("post_rst_v1", 64'(v1),  64'd1);

      // exhaustive 1-bit truth table, back to back
      for (int k = 0; k < 8; k++) begin
         logic [2:0] kv;
         kv = 3'(k);
         {a1, b1, c01} = kv;
         tick();
         chk($sformatf("tt%0d", k), 64'({s1, co1}), 64'(tab[k]));
      end

      // hold
      a1 = 1'b1; b1 = 1'b0; c01 = 1'b1;
      tick();
      en = 1'b0; a1 = 1'b0; b1 = 1'b0; c01 = 1'b0;
      repeat (3) begin
         tick();
         chk("hold_s1", 64'(s1),  64'd0);
         chk("hold_c1", 64'(co1), 64'd1);
         chk("hold_v1", 64'(v1),  64'd0);
      end

      // 8-bit overflow and carry chain
      en = 1'b1;
      drive8(8'hFF, 8'h01, 1'b0); tick();
      chk("ovf_s8", 64'(s8), 64'h00); chk("ovf_c8", 64'(co8), 64'd1);
      drive8(8'hFF, 8'hFF, 1'b1); tick();
      chk("max_s8", 64'(s8), 64'hFF); chk("max_c8", 64'(co8), 64'd1);
      drive8(8'h7F, 8'h00, 1'b1); tick();
      chk("chain_s8", 64'(s8), 64'h80); chk("chain_c8", 64'(co8), 64'd0);
      drive8(8'h55, 8'hAA, 1'b0); tick();
      chk("alt_s8", 64'(s8), 64'hFF); chk("alt_c8", 64'(co8), 64'd0);

      // reset mid-stream discards the operand on that edge
      rst = 1'b1; drive8(8'h80, 8'h80, 1'b0); tick();
      chk("mid_rst_s8", 64'(s8), 64'h00); chk("mid_rst_v8", 64'(v8), 64'd0);
      rst = 1'b0; tick();
      chk("mid_s8", 64'(s8), 64'h00); chk("mid_c8", 64'(co8), 64'd1);
      chk("mid_v8", 64'(v8), 64'd1);

      // random traffic
      for (int n = 0; n < 300; n++) begin
         rst = ($urandom_range(0, 15) == 0);
         en  = ($urandom_range(0, 3) != 0);
         a1 = 1'($urandom); b1 = 1'($urandom); c01 = 1'($urandom);
         drive8(8'($urandom), 8'($urandom), 1'($urandom));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry full adder. Computes {C1,S} = A + B + C0 and registers the result on the rising clock edge.
- WIDTH=1 is the classic single-bit full adder. Wider instances chain 1-bit cells internally.
- Used as a leaf arithmetic primitive in the datapath, e.g. delta-sigma accumulator stages.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  operand valid / capture enable.
- A  input  WIDTH  addend A, unsigned.
- B  input  WIDTH  addend B, unsigned.
- C0  input  1  carry-in.
- S  output  WIDTH  registered sum, (A+B+C0) mod 2^WIDTH.
- C1  output  1  registered carry-out, bit WIDTH of A+B+C0.
- valid  output  1  high for one cycle when S/C1 hold a result captured on the previous edge.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset: on a rising edge with rst=1, S=0, C1=0 and valid=0. rst overrides en.
- Capture: on a rising edge with rst=0 and en=1:
  - S <= low WIDTH bits of A+B+C0.
  - C1 <= carry out of the MSB cell.
  - valid <= 1.
- Hold: on a rising edge with rst=0 and en=0, S and C1 hold their values and valid <= 0.
- Latency: exactly 1 cycle from input sample to output. Throughput is one operation per cycle; back-to-back en is allowed.
- Per-bit logic:
  - Bit-cell i computes s_i = a_i ^ b_i ^ c_i and c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = C0. C1 = c_WIDTH.
- Arithmetic is unsigned with no saturation; overflow appears only on C1.
- WIDTH=1 truth table (A,B,C0 -> S,C1):
  - 000 -> 0,0; 001 -> 1,0; 010 -> 1,0; 011 -> 0,1.
  - 100 -> 1,0; 101 -> 0,1; 110 -> 0,1; 111 -> 1,1.
- Input X/Z propagation is not specified. Inputs are required to be known whenever en=1.
- Reset asserted mid-stream discards the in-flight operation. The first valid after rst deasserts follows the first en=1 edge.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - FA_MAX_WIDTH = 64.
  - The default width constant.
  - A packed result struct {logic c1; logic [WIDTH-1:0] s;} for consumers that bundle the outputs.
- One natural sub-module: fa_cell, a purely combinational 1-bit full adder (a, b, ci -> s, co).
- full_adder instantiates WIDTH fa_cell copies in a generate loop and adds the output register stage.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1 and A=B=C0=1 -> S=0, C1=0, valid=0 on each edge; rst then low -> first en edge yields S=1, C1=1, valid=1.
- WIDTH=1 exhaustive: apply the 8 combos 000,001,010,011,100,101,110,111 with en=1 on consecutive cycles -> one cycle later (S,C1) = (0,0),(1,0),(1,0),(0,1),(1,0),(0,1),(0,1),(1,1), with valid=1 on every cycle.
- Hold: capture A=1, B=0, C0=1 (S=0, C1=1), then drive en=0 with A=B=C0=0 for 3 cycles -> S=0, C1=1 unchanged and valid=0.
- WIDTH=8 overflow: A=0xFF, B=0x01, C0=0 -> S=0x00, C1=1. Then A=0xFF, B=0xFF, C0=1 -> S=0xFF, C1=1.
- WIDTH=8 carry chain: A=0x7F, B=0x00, C0=1 -> S=0x80, C1=0. A=0x55, B=0xAA, C0=0 -> S=0xFF, C1=0.
- Reset mid-stream: en=1 with A=0x80, B=0x80 (WIDTH=8) while rst=1 on the same edge -> S=0, C1=0, valid=0; the next edge with rst=0 yields S=0x00, C1=1.
